fetch_regs: RTL and testbench
=============================

# fetch_regs

Multicycle datapath register stage that sits directly upstream of `Control_Unit`. It holds the program counter, instruction register, memory data register, register-file operand latches and ALU output latch. It presents the memory address selected by `I_or_D`, and decodes the latched instruction into the `Op` and `Funct` fields the control unit consumes. It acts on `Control_Unit` outputs (`PC_Write`, `IR_Write`, `I_or_D`, `PC_Src`) and captures memory and ALU results on each rising clock edge.

## Interface
- `WIDTH`, 32: datapath word width; instruction format is fixed at 32 bits, so `WIDTH` must be 32.
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 clears state immediately.
- `PC_Write`  input  1  load enable for PC.
- `IR_Write`  input  1  load enable for IR.
- `I_or_D`  input  1  address select: 0 = PC, 1 = ALU_Out.
- `PC_Src`  input  1  next-PC select: 0 = ALU_Result, 1 = ALU_Out.
- `ALU_Result`  input  WIDTH  combinational ALU output.
- `Mem_Read_Data`  input  WIDTH  unified memory read data; combinational w.r.t. `Mem_Addr`.
- `Reg_Read_Data1`  input  WIDTH  register file port 1 (rs).
- `Reg_Read_Data2`  input  WIDTH  register file port 2 (rt).
- `Mem_Addr`  output  WIDTH  memory address.
- `PC`  output  WIDTH  current PC.
- `Instr`  output  32  IR contents.
- `Op`  output  6  Instr[31:26], to `Control_Unit.Op`.
- `Funct`  output  6  Instr[5:0], to `Control_Unit.Funct`.
- `Rs`, `Rt`, `Rd`  output  5 each  Instr[25:21], [20:16], [15:11].
- `Imm_Ext`  output  WIDTH  Instr[15:0] sign-extended.
- `Data`  output  WIDTH  memory data register (MDR).
- `A`, `B`  output  WIDTH each  operand latches.
- `ALU_Out`  output  WIDTH  ALU result latch.
- `Instr_Count`  output  32  number of instruction fetches since reset.

## Operation
- PC: on edge with `PC_Write`=1, PC <= (`PC_Src` ? ALU_Out : ALU_Result); otherwise PC holds.
- IR: on edge with `IR_Write`=1, IR <= `Mem_Read_Data`; otherwise IR holds. Op, Funct, Rs, Rt, Rd and Imm_Ext derive combinationally from IR only, never from `Mem_Read_Data`.
- Data, A, B, ALU_Out: load unconditionally every edge from `Mem_Read_Data`, `Reg_Read_Data1`, `Reg_Read_Data2` and `ALU_Result` respectively.
- `Mem_Addr` = `I_or_D` ? ALU_Out : PC; purely combinational from registered values and the select.
- Instr_Count: +1 on each edge with `IR_Write`=1; wraps 32'hFFFF_FFFF -> 0 with no flag.
- Reset (`reset`=0): asynchronous.
  - PC = `RESET_PC`.
  - IR, Data, A, B, ALU_Out and Instr_Count = 0.
  - Therefore Op = 0, Funct = 0, Imm_Ext = 0, and `Mem_Addr` = `RESET_PC` when `I_or_D`=0.
  - Applies mid-instruction with no completion of the pending update; release is synchronous to the next rising edge.

## Timing
- All register outputs change only at the rising clock edge or on reset assertion.
- Fetch-state edge with `PC_Write`=`IR_Write`=1 and `I_or_D`=0:
  - IR captures the word at the old PC.
  - PC takes ALU_Result (PC+4) on the same edge.
- Op/Funct are valid one cycle after the `IR_Write` edge, which is the decode state; the control unit samples them there.
- Branch: ALU_Out latched in decode; in the branch state, `PC_Src`=1 with `PC_Write`=1 loads the target at that edge.
- Load: `Mem_Addr` = ALU_Out in the memory-read state; Data is valid the following cycle for `Mem_to_Reg`.
- `PC_Write`=0 with `PC_Src` toggling: PC unchanged.
- `IR_Write`=0: IR and Instr_Count unchanged regardless of `Mem_Read_Data`.

## Test plan
- Reset and release:
  - Stimulus: hold `reset`=0 for 2 cycles with `RESET_PC`=0, then release.
  - Response: PC=0, Op=0, Funct=0, Instr_Count=0; `Mem_Addr`=0 with `I_or_D`=0.
- Fetch:
  - Stimulus: `Mem_Read_Data`=32'h2008_0005 (ADDI), `ALU_Result`=4, `PC_Write`=`IR_Write`=1 for one edge.
  - Response: PC=4, Op=6'b001000, Imm_Ext=5, Instr_Count=1.
- R-type decode:
  - Stimulus: fetch 32'h0109_5020 (ADD).
  - Response: Op=0, Funct=6'b100000, Rs=8, Rt=9, Rd=10; IR holds after `IR_Write` drops even if `Mem_Read_Data` changes.
- Branch and sign extension:
  - Stimulus: latch ALU_Out=32'h0000_0040; next edge `PC_Src`=1, `PC_Write`=1, with `ALU_Result`=32'hDEAD.
  - Response: PC=32'h40.
  - Stimulus: Imm field 16'hFFFC.
  - Response: Imm_Ext=32'hFFFF_FFFC.
- Data address:
  - Stimulus: `I_or_D`=1 with ALU_Out=32'h100.
  - Response: `Mem_Addr`=32'h100.
  - Stimulus: next edge with `Mem_Read_Data`=32'h1234.
  - Response: Data=32'h1234.
- Asynchronous reset mid-instruction:
  - Stimulus: assert `reset`=0 between edges after PC=8.
  - Response: PC=0 and IR=0 immediately, before the next edge.
  - Stimulus: preload Instr_Count=32'hFFFF_FFFF, then fetch.
  - Response: Instr_Count wraps to 0.

Source files
------------

// File: rtl/fetch_regs.sv
// Multicycle datapath register stage: PC, IR, MDR, operand and ALU latches.
// Decodes the latched instruction for the control unit and selects the memory address.
module fetch_regs #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_Write,
    input  logic             IR_Write,
    input  logic             I_or_D,
    input  logic             PC_Src,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [WIDTH-1:0] Mem_Read_Data,
    input  logic [WIDTH-1:0] Reg_Read_Data1,
    input  logic [WIDTH-1:0] Reg_Read_Data2,
    output logic [WIDTH-1:0] Mem_Addr,
    output logic [WIDTH-1:0] PC,
    output logic [31:0]      Instr,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [WIDTH-1:0] Imm_Ext,
    output logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [31:0]      Instr_Count
);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [31:0]      ir_reg;
    logic [WIDTH-1:0] data_reg, a_reg, b_reg, alu_out_reg;
    logic [31:0]      instr_count_reg;

    assign pc_next = PC_Src ? alu_out_reg : ALU_Result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= RESET_PC;
            ir_reg          <= '0;
            instr_count_reg <= '0;
        end else begin
            if (PC_Write) begin
                pc_reg <= pc_next;
            end
            // The fetch count tracks IR loads and wraps silently.
            if (IR_Write) begin
                ir_reg          <= Mem_Read_Data;
                instr_count_reg <= instr_count_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
        end else begin
            data_reg    <= Mem_Read_Data;
            a_reg       <= Reg_Read_Data1;
            b_reg       <= Reg_Read_Data2;
            alu_out_reg <= ALU_Result;
        end
    end

    // Decode only from the latched instruction so the control unit sees a stable word.
    assign Op      = ir_reg[31:26];
    assign Rs      = ir_reg[25:21];
    assign Rt      = ir_reg[20:16];
    assign Rd      = ir_reg[15:11];
    assign Funct   = ir_reg[5:0];
    assign Imm_Ext = {{(WIDTH-16){ir_reg[15]}}, ir_reg[15:0]};

    assign Mem_Addr    = I_or_D ? alu_out_reg : pc_reg;
    assign PC          = pc_reg;
    assign Instr       = ir_reg;
    assign Data        = data_reg;
    assign A           = a_reg;
    assign B           = b_reg;
    assign ALU_Out     = alu_out_reg;
    assign Instr_Count = instr_count_reg;

endmodule

// File: tb/tb_fetch_regs.sv
// Bench for fetch_regs: directed vector table, hand-written reset/wrap sequences,
// and randomized traffic compared against a behavioural model.
module tb_fetch_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_Write, IR_Write, I_or_D, PC_Src;
    logic [31:0] ALU_Result, Mem_Read_Data, Reg_Read_Data1, Reg_Read_Data2;
    logic [31:0] Mem_Addr, PC, Instr, Imm_Ext, Data, A, B, ALU_Out, Instr_Count;
    logic [5:0]  Op, Funct;
    logic [4:0]  Rs, Rt, Rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_regs #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .PC_Write(PC_Write), .IR_Write(IR_Write), .I_or_D(I_or_D), .PC_Src(PC_Src),
        .ALU_Result(ALU_Result), .Mem_Read_Data(Mem_Read_Data),
        .Reg_Read_Data1(Reg_Read_Data1), .Reg_Read_Data2(Reg_Read_Data2),
        .Mem_Addr(Mem_Addr), .PC(PC), .Instr(Instr), .Op(Op), .Funct(Funct),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm_Ext(Imm_Ext), .Data(Data),
        .A(A), .B(B), .ALU_Out(ALU_Out), .Instr_Count(Instr_Count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pw, iw, iod, src;
        logic [31:0] alu, mem;
        logic [31:0] e_pc, e_instr, e_imm, e_cnt, e_data, e_alu_out, e_addr;
        logic [5:0]  e_op, e_funct;
        logic [4:0]  e_rs, e_rt, e_rd;
    } vec_t;

    vec_t vecs[7];

    // Behavioural model state
    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_alu_out, m_cnt;

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_alu_out = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] old_alu_out;
        old_alu_out = m_alu_out;
        if (PC_Write) m_pc = PC_Src ? old_alu_out : ALU_Result;
        if (IR_Write) begin
            m_ir  = Mem_Read_Data;
            m_cnt = m_cnt + 1;
        end
        m_data    = Mem_Read_Data;
        m_a       = Reg_Read_Data1;
        m_b       = Reg_Read_Data2;
        m_alu_out = ALU_Result;
    endtask

    task automatic check_model();
        int          imm;
        logic [31:0] imm_exp;
        imm     = int'($signed(m_ir[15:0]));
        imm_exp = imm;
        check("pc", PC, m_pc);
        check("instr", Instr, m_ir);
        check("op", {26'd0, Op}, m_ir / 32'h0400_0000);
        check("funct", {26'd0, Funct}, m_ir % 64);
        check("rs", {27'd0, Rs}, (m_ir / 32'h20_0000) % 32);
        check("rt", {27'd0, Rt}, (m_ir / 32'h1_0000) % 32);
        check("rd", {27'd0, Rd}, (m_ir / 32'h800) % 32);
        check("imm_ext", Imm_Ext, imm_exp);
        check("data", Data, m_data);
        check("a", A, m_a);
        check("b", B, m_b);
        check("alu_out", ALU_Out, m_alu_out);
        check("mem_addr", Mem_Addr, I_or_D ? m_alu_out : m_pc);
        check("instr_count", Instr_Count, m_cnt);
    endtask

    task automatic drive(input logic pw, iw, iod, src, input logic [31:0] alu, mem);
        PC_Write = pw; IR_Write = iw; I_or_D = iod; PC_Src = src;
        ALU_Result = alu; Mem_Read_Data = mem;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // pw iw iod src alu mem | pc instr imm cnt data alu_out addr op funct rs rt rd
        vecs[0] = '{1,1,0,0, 32'h4,    32'h2008_0005, 32'h4,  32'h2008_0005, 32'h5,         1, 32'h2008_0005, 32'h4,    32'h4,   6'h08, 6'h05, 5'd0, 5'd8, 5'd0};
        vecs[1] = '{1,1,0,0, 32'h8,    32'h0109_5020, 32'h8,  32'h0109_5020, 32'h5020,      2, 32'h0109_5020, 32'h8,    32'h8,   6'h00, 6'h20, 5'd8, 5'd9, 5'd10};
        vecs[2] = '{0,0,0,1, 32'h40,   32'hFFFF_FFFF, 32'h8,  32'h0109_5020, 32'h5020,      2, 32'hFFFF_FFFF, 32'h40,   32'h8,   6'h00, 6'h20, 5'd8, 5'd9, 5'd10};
        vecs[3] = '{1,0,0,1, 32'hDEAD, 32'h0,         32'h40, 32'h0109_5020, 32'h5020,      2, 32'h0,         32'hDEAD, 32'h40,  6'h00, 6'h20, 5'd8, 5'd9, 5'd10};
        vecs[4] = '{1,1,0,0, 32'h44,   32'h2004_FFFC, 32'h44, 32'h2004_FFFC, 32'hFFFF_FFFC, 3, 32'h2004_FFFC, 32'h44,   32'h44,  6'h08, 6'h3C, 5'd0, 5'd4, 5'd31};
        vecs[5] = '{0,0,1,1, 32'h100,  32'h0,         32'h44, 32'h2004_FFFC, 32'hFFFF_FFFC, 3, 32'h0,         32'h100,  32'h100, 6'h08, 6'h3C, 5'd0, 5'd4, 5'd31};
        vecs[6] = '{0,0,1,0, 32'h100,  32'h1234,      32'h44, 32'h2004_FFFC, 32'hFFFF_FFFC, 3, 32'h1234,      32'h100,  32'h100, 6'h08, 6'h3C, 5'd0, 5'd4, 5'd31};

        reset = 1'b0;
        Reg_Read_Data1 = 0; Reg_Read_Data2 = 0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        $display("reset: pc=%h op=%h funct=%h cnt=%h addr=%h", PC, Op, Funct, Instr_Count, Mem_Addr);
        check("reset_pc", PC, 32'h0);
        check("reset_op", {26'd0, Op}, 32'h0);
        check("reset_funct", {26'd0, Funct}, 32'h0);
        check("reset_imm", Imm_Ext, 32'h0);
        check("reset_count", Instr_Count, 32'h0);
        check("reset_mem_addr", Mem_Addr, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].pw, vecs[i].iw, vecs[i].iod, vecs[i].src, vecs[i].alu, vecs[i].mem);
            @(posedge clk);
            @(negedge clk);
            $display("vec %0d: pc=%h instr=%h cnt=%0d addr=%h data=%h", i, PC, Instr, Instr_Count, Mem_Addr, Data);
            check("vec_pc", PC, vecs[i].e_pc);
            check("vec_instr", Instr, vecs[i].e_instr);
            check("vec_imm", Imm_Ext, vecs[i].e_imm);
            check("vec_count", Instr_Count, vecs[i].e_cnt);
            check("vec_data", Data, vecs[i].e_data);
            check("vec_alu_out", ALU_Out, vecs[i].e_alu_out);
            check("vec_mem_addr", Mem_Addr, vecs[i].e_addr);
            check("vec_op", {26'd0, Op}, {26'd0, vecs[i].e_op});
            check("vec_funct", {26'd0, Funct}, {26'd0, vecs[i].e_funct});
            check("vec_rs", {27'd0, Rs}, {27'd0, vecs[i].e_rs});
            check("vec_rt", {27'd0, Rt}, {27'd0, vecs[i].e_rt});
            check("vec_rd", {27'd0, Rd}, {27'd0, vecs[i].e_rd});
        end

        // Asynchronous reset between edges, with PC at 8
        drive(1, 1, 0, 0, 32'h8, 32'h0109_5020);
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_pc", PC, 32'h8);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        $display("async reset: pc=%h instr=%h data=%h cnt=%h", PC, Instr, Data, Instr_Count);
        check("async_pc", PC, 32'h0);
        check("async_instr", Instr, 32'h0);
        check("async_alu_out", ALU_Out, 32'h0);
        check("async_count", Instr_Count, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Counter wrap: preload all ones, then one fetch
        force dut.instr_count_reg = 32'hFFFF_FFFF;
        #1 release dut.instr_count_reg;
        #1;
        check("preload_count", Instr_Count, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0, 32'h4, 32'h2008_0005);
        @(posedge clk);
        @(negedge clk);
        $display("wrap: cnt=%h pc=%h", Instr_Count, PC);
        check("wrap_count", Instr_Count, 32'h0);
        check("wrap_pc", PC, 32'h4);

        // Randomized traffic against the behavioural model
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        for (int t = 0; t < 300; t++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            Reg_Read_Data1 = $urandom;
            Reg_Read_Data2 = $urandom;
            reset = ($urandom_range(0, 29) != 0);
            @(posedge clk);
            if (!reset) model_reset();
            else model_edge();
            @(negedge clk);
            if (!reset) model_reset();
            $display("rand %0d: rst=%b pw=%b iw=%b pc=%h instr=%h cnt=%0d", t, reset, PC_Write, IR_Write, PC, Instr, Instr_Count);
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
